// File: rtl/k_band_energy_scheduler.sv
// Feeds FFT bins one at a time through the shared energy unit and accumulates
// the returned energies into programmable frequency bands, one vector per frame.
module k_band_energy_scheduler #(
    parameter int unsigned IN_WIDTH  = 16,
    parameter int unsigned E_WIDTH   = 40,
    parameter int unsigned NUM_BANDS = 4,
    parameter int unsigned IDX_WIDTH = 10,
    parameter int unsigned ACC_WIDTH = 48
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic [2*IN_WIDTH-1:0]          s_axis_tdata,
    input  logic                           s_axis_tlast,
    output logic                           e_tvalid,
    input  logic                           e_tready,
    output logic [2*IN_WIDTH-1:0]          e_tdata,
    input  logic [E_WIDTH-1:0]             e_energy,
    input  logic                           e_valid,
    input  logic [NUM_BANDS*IDX_WIDTH-1:0] band_edge,
    output logic [NUM_BANDS*ACC_WIDTH-1:0] m_band_energy,
    output logic [NUM_BANDS-1:0]           m_band_sat,
    output logic                           m_valid,
    input  logic                           m_ready
);

    localparam int unsigned SUM_W  = ((ACC_WIDTH > E_WIDTH) ? ACC_WIDTH : E_WIDTH) + 1;
    localparam int unsigned BAND_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACCUM, OUTPUT} state_t;

    state_t                 state, state_nxt;
    logic                   run;
    logic [2*IN_WIDTH-1:0]  data_q;
    logic                   last_q;
    logic [IDX_WIDTH-1:0]   bin_idx;
    logic [IDX_WIDTH-1:0]   bin_cnt;
    logic [IDX_WIDTH-1:0]   edge_q [NUM_BANDS];
    logic [E_WIDTH-1:0]     energy_q;
    logic [ACC_WIDTH-1:0]   acc [NUM_BANDS];
    logic [NUM_BANDS-1:0]   sat;
    logic                   band_hit;
    logic [BAND_W-1:0]      band_sel;
    logic [SUM_W-1:0]       sum;
    logic                   sum_ovf;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // run holds s_axis_tready low for the first cycle after reset release
    always_comb begin
        state_nxt     = state;
        s_axis_tready = 1'b0;
        e_tvalid      = 1'b0;
        m_valid       = 1'b0;
        case (state)
            IDLE: begin
                s_axis_tready = run;
                if (run && s_axis_tvalid) state_nxt = ISSUE;
            end
            ISSUE: begin
                e_tvalid = 1'b1;
                if (e_tready) state_nxt = WAIT;
            end
            WAIT:   if (e_valid) state_nxt = ACCUM;
            ACCUM:  state_nxt = last_q ? OUTPUT : IDLE;
            OUTPUT: begin
                m_valid = 1'b1;
                if (m_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Lowest band whose inclusive upper edge covers the bin wins
    always_comb begin
        band_hit = 1'b0;
        band_sel = '0;
        for (int unsigned b = 0; b < NUM_BANDS; b++) begin
            if (!band_hit && bin_idx <= edge_q[b]) begin
                band_hit = 1'b1;
                band_sel = BAND_W'(b);
            end
        end
        sum     = SUM_W'(acc[band_sel]) + SUM_W'(energy_q);
        sum_ovf = |sum[SUM_W-1:ACC_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run      <= 1'b0;
            data_q   <= '0;
            last_q   <= 1'b0;
            bin_idx  <= '0;
            bin_cnt  <= '0;
            energy_q <= '0;
            sat      <= '0;
            for (int unsigned b = 0; b < NUM_BANDS; b++) begin
                acc[b]    <= '0;
                edge_q[b] <= '0;
            end
        end else begin
            run <= 1'b1;
            case (state)
                IDLE: begin
                    if (s_axis_tready && s_axis_tvalid) begin
                        data_q  <= s_axis_tdata;
                        last_q  <= s_axis_tlast;
                        bin_idx <= bin_cnt;
                        if (bin_cnt == '0) begin
                            for (int unsigned b = 0; b < NUM_BANDS; b++)
                                edge_q[b] <= band_edge[b*IDX_WIDTH +: IDX_WIDTH];
                        end
                    end
                end
                WAIT: if (e_valid) energy_q <= e_energy;
                ACCUM: begin
                    if (band_hit) begin
                        if (sum_ovf) begin
                            acc[band_sel] <= '1;
                            sat[band_sel] <= 1'b1;
                        end else begin
                            acc[band_sel] <= sum[ACC_WIDTH-1:0];
                        end
                    end
                    if (bin_cnt != '1) bin_cnt <= bin_cnt + IDX_WIDTH'(1);
                end
                OUTPUT: begin
                    if (m_ready) begin
                        sat     <= '0;
                        bin_cnt <= '0;
                        for (int unsigned b = 0; b < NUM_BANDS; b++) acc[b] <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign e_tdata    = data_q;
    assign m_band_sat = sat;

    always_comb begin
        m_band_energy = '0;
        for (int unsigned b = 0; b < NUM_BANDS; b++)
            m_band_energy[b*ACC_WIDTH +: ACC_WIDTH] = acc[b];
    end

endmodule

// File: tb/tb_k_band_energy_scheduler.sv
// Directed bench for k_band_energy_scheduler with a latency-3 energy-unit model.
module tb_k_band_energy_scheduler;

    localparam int IN_W = 16;
    localparam int E_W  = 40;
    localparam int NB   = 4;
    localparam int IW   = 10;
    localparam int AW   = 33;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [2*IN_W-1:0] s_axis_tdata;
    logic              s_axis_tlast;
    logic              e_tvalid;
    logic              e_tready;
    logic [2*IN_W-1:0] e_tdata;
    logic [E_W-1:0]    e_energy = '0;
    logic              e_valid = 1'b0;
    logic [NB*IW-1:0]  band_edge;
    logic [NB*AW-1:0]  m_band_energy;
    logic [NB-1:0]     m_band_sat;
    logic              m_valid;
    logic              m_ready;

    logic              e_rdy = 1'b1;
    logic [3:0]        lat_cnt = '0;
    logic [E_W-1:0]    e_pend = '0;
    int                tests = 0;
    int                fails = 0;
    logic [AW-1:0]     held;

    always #5 clk = ~clk;
    assign e_tready = e_rdy;

    k_band_energy_scheduler #(
        .IN_WIDTH (IN_W),
        .E_WIDTH  (E_W),
        .NUM_BANDS(NB),
        .IDX_WIDTH(IW),
        .ACC_WIDTH(AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tlast (s_axis_tlast),
        .e_tvalid     (e_tvalid),
        .e_tready     (e_tready),
        .e_tdata      (e_tdata),
        .e_energy     (e_energy),
        .e_valid      (e_valid),
        .band_edge    (band_edge),
        .m_band_energy(m_band_energy),
        .m_band_sat   (m_band_sat),
        .m_valid      (m_valid),
        .m_ready      (m_ready)
    );

    function automatic logic [E_W-1:0] energy_of(input logic [2*IN_W-1:0] d);
        longint r, i;
        r = longint'($signed(d[2*IN_W-1:IN_W]));
        i = longint'($signed(d[IN_W-1:0]));
        return E_W'(r * r + i * i);
    endfunction

    // External energy unit: not reset, so late results survive a DUT reset
    always @(posedge clk) begin
        e_valid <= 1'b0;
        if (lat_cnt != 0) begin
            lat_cnt <= lat_cnt - 4'd1;
            if (lat_cnt == 4'd1) begin
                e_valid  <= 1'b1;
                e_energy <= e_pend;
            end
        end
        if (e_tvalid && e_tready) begin
            lat_cnt <= 4'd3;
            e_pend  <= energy_of(e_tdata);
        end
    end

    function automatic logic [AW-1:0] band_of(input int b);
        return m_band_energy[b*AW +: AW];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_bands(input string tag, input logic [AW-1:0] b0, input logic [AW-1:0] b1,
                               input logic [AW-1:0] b2, input logic [AW-1:0] b3, input logic [3:0] s);
        check({tag, "_band0"}, 64'(band_of(0)), 64'(b0));
        check({tag, "_band1"}, 64'(band_of(1)), 64'(b1));
        check({tag, "_band2"}, 64'(band_of(2)), 64'(b2));
        check({tag, "_band3"}, 64'(band_of(3)), 64'(b3));
        check({tag, "_sat"}, 64'(m_band_sat), 64'(s));
    endtask

    task automatic send_bin(input logic [IN_W-1:0] re, input logic [IN_W-1:0] im, input logic last);
        int n;
        @(negedge clk);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {re, im};
        s_axis_tlast  = last;
        n = 0;
        while (!s_axis_tready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bin_accept", 64'(s_axis_tready), 64'd1);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_frame(input int nbins, input logic [IN_W-1:0] re, input logic [IN_W-1:0] im);
        for (int i = 0; i < nbins; i++) send_bin(re, im, i == nbins - 1);
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        @(negedge clk);
        while (!m_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("m_valid_rise", 64'(m_valid), 64'd1);
    endtask

    task automatic ack();
        @(negedge clk);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        check("ack_m_valid_fall", 64'(m_valid), 64'd0);
        check("ack_tready_rise", 64'(s_axis_tready), 64'd1);
        check("ack_band0_clear", 64'(band_of(0)), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = '0;
        s_axis_tlast = 1'b0;
        m_ready = 1'b0;
        band_edge = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tready", 64'(s_axis_tready), 64'd0);
        check("rst_e_tvalid", 64'(e_tvalid), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_e_tdata", 64'(e_tdata), 64'd0);
        check_bands("rst", '0, '0, '0, '0, 4'b0000);
        rst = 1'b0;
        #1 check("tready_low_at_release", 64'(s_axis_tready), 64'd0);
        @(negedge clk);
        check("tready_after_release", 64'(s_axis_tready), 64'd1);

        // Uniform 8-bin frame across four two-bin bands
        band_edge = {10'd7, 10'd5, 10'd3, 10'd1};
        send_bin(16'd3, 16'd4, 1'b0);
        check("issue_e_tvalid", 64'(e_tvalid), 64'd1);
        check("issue_e_tdata", 64'(e_tdata), 64'h0003_0004);
        check("issue_tready_low", 64'(s_axis_tready), 64'd0);
        for (int i = 1; i < 7; i++) send_bin(16'd3, 16'd4, 1'b0);
        check("no_early_m_valid", 64'(m_valid), 64'd0);
        send_bin(16'd3, 16'd4, 1'b1);
        wait_result();
        check_bands("s1", 33'd50, 33'd50, 33'd50, 33'd50, 4'b0000);
        ack();

        // Overlapping edges; edge input changes mid-frame must not matter
        band_edge = {10'd2, 10'd0, 10'd0, 10'd0};
        send_bin(16'd1, 16'd0, 1'b0);
        band_edge = '1;
        for (int i = 1; i < 5; i++) send_bin(16'd1, 16'd0, i == 4);
        wait_result();
        check_bands("s2", 33'd1, 33'd0, 33'd0, 33'd2, 4'b0000);
        ack();

        // Saturation: four bins of energy 2^31 into a 33-bit accumulator
        band_edge = {4{10'd3}};
        send_frame(4, 16'h8000, 16'h8000);
        wait_result();
        check_bands("s3", 33'h1_FFFF_FFFF, 33'd0, 33'd0, 33'd0, 4'b0001);

        // Hold result with a bin waiting at the input
        held = band_of(0);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {16'd2, 16'd0};
        s_axis_tlast  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_m_valid", 64'(m_valid), 64'd1);
            check("hold_band0", 64'(band_of(0)), 64'(held));
            check("hold_tready", 64'(s_axis_tready), 64'd0);
            check("hold_e_tvalid", 64'(e_tvalid), 64'd0);
        end
        check("hold_sat", 64'(m_band_sat), 64'd1);
        @(negedge clk);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        check("hold_ack_m_valid", 64'(m_valid), 64'd0);
        check("hold_ack_tready", 64'(s_axis_tready), 64'd1);
        check("hold_ack_band0", 64'(band_of(0)), 64'd0);
        check("hold_ack_sat", 64'(m_band_sat), 64'd0);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        check("next_frame_issue", 64'(e_tvalid), 64'd1);
        wait_result();
        check_bands("s4", 33'd4, 33'd0, 33'd0, 33'd0, 4'b0000);
        ack();

        // Energy unit back-pressure during ISSUE
        band_edge = {10'd7, 10'd5, 10'd3, 10'd1};
        e_rdy = 1'b0;
        send_bin(16'd3, 16'd4, 1'b0);
        s_axis_tdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_e_tvalid", 64'(e_tvalid), 64'd1);
            check("stall_e_tdata", 64'(e_tdata), 64'h0003_0004);
        end
        e_rdy = 1'b1;
        for (int i = 1; i < 8; i++) send_bin(16'd3, 16'd4, i == 7);
        wait_result();
        check_bands("s5", 33'd50, 33'd50, 33'd50, 33'd50, 4'b0000);
        ack();

        // Reset after 3 bins while the third is at the energy unit
        for (int i = 0; i < 3; i++) send_bin(16'd3, 16'd4, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_e_tvalid", 64'(e_tvalid), 64'd0);
        check("midrst_e_tdata", 64'(e_tdata), 64'd0);
        check("midrst_m_valid", 64'(m_valid), 64'd0);
        check("midrst_tready", 64'(s_axis_tready), 64'd0);
        check_bands("midrst", '0, '0, '0, '0, 4'b0000);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("late_e_valid_ignored", 64'(band_of(0)), 64'd0);
        send_frame(8, 16'd3, 16'd4);
        wait_result();
        check_bands("s6", 33'd50, 33'd50, 33'd50, 33'd50, 4'b0000);
        ack();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
